// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a 4-bit ALU datapath: accepts a command, drives the
// operand/select lines for SETTLE cycles, captures the mux output and hands it off.
module alu_seq_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_chain,
   output logic [1:0] selector,
   output logic [3:0] opnd_a,
   output logic [3:0] opnd_b,
   input  logic [3:0] fout,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic       res_zero,
   output logic [7:0] op_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

   logic [1:0] state;
   logic [3:0] settle_cnt;
   logic [3:0] last_res;
   logic       accept;
   logic       handoff;
   logic       settle_done;

   assign accept      = (state == IDLE) && cmd_ready && cmd_valid;
   assign handoff     = (state == DONE) && res_ready;
   assign settle_done = (state == EXEC) && (settle_cnt == LAST_CNT);
   assign res_valid   = (state == DONE);
   assign res_data    = last_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (accept)      state <= EXEC;
            EXEC:    if (settle_done) state <= DONE;
            DONE:    if (res_ready)   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Registered ready: low during reset, never high on the edge that hands a result off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready <= 1'b0;
      end else begin
         cmd_ready <= ((state == IDLE) && !accept) || handoff;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         selector <= 2'b00;
         opnd_a   <= 4'b0000;
         opnd_b   <= 4'b0000;
      end else if (accept) begin
         selector <= cmd_op;
         opnd_a   <= cmd_chain ? last_res : cmd_a;
         opnd_b   <= cmd_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= 4'd0;
      end else if (accept) begin
         settle_cnt <= 4'd0;
      end else if ((state == EXEC) && !settle_done) begin
         settle_cnt <= settle_cnt + 4'd1;
      end
   end

   // The captured result doubles as the chain operand for the next command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_res <= 4'b0000;
         res_zero <= 1'b0;
      end else if (settle_done) begin
         last_res <= fout;
         res_zero <= (fout == 4'b0000);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt <= 8'd0;
      end else if (handoff) begin
         op_cnt <= op_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: two instances (SETTLE=1 and SETTLE=3) checked every cycle
// against a transaction-level model, plus literal expectations for the key vectors.
module tb_alu_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       v1 = 1'b0, ch1 = 1'b0, rr1 = 1'b0;
   logic [1:0] op1 = 2'd0;
   logic [3:0] a1 = 4'd0, b1 = 4'd0;
   logic       rdy1, rv1, z1;
   logic [1:0] sel1;
   logic [3:0] oa1, ob1, rd1, f1;
   logic [7:0] cnt1;

   logic       v3 = 1'b0, ch3 = 1'b0, rr3 = 1'b0;
   logic [1:0] op3 = 2'd0;
   logic [3:0] a3 = 4'd0, b3 = 4'd0;
   logic       rdy3, rv3, z3;
   logic [1:0] sel3;
   logic [3:0] oa3, ob3, rd3, f3;
   logic [7:0] cnt3;

   int checks = 0;
   int errors = 0;
   logic started = 1'b0;

   function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   assign f1 = alu_ref(sel1, oa1, ob1);
   assign f3 = alu_ref(sel3, oa3, ob3);

   alu_seq_ctrl #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
      .cmd_a(a1), .cmd_b(b1), .cmd_chain(ch1), .selector(sel1), .opnd_a(oa1),
      .opnd_b(ob1), .fout(f1), .res_valid(rv1), .res_ready(rr1), .res_data(rd1),
      .res_zero(z1), .op_cnt(cnt1)
   );

   alu_seq_ctrl #(.SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(op3),
      .cmd_a(a3), .cmd_b(b3), .cmd_chain(ch3), .selector(sel3), .opnd_a(oa3),
      .opnd_b(ob3), .fout(f3), .res_valid(rv3), .res_ready(rr3), .res_data(rd3),
      .res_zero(z3), .op_cnt(cnt3)
   );

   // Model state per instance: an in-flight transaction with a due cycle, not an FSM.
   logic       m_busy [2];
   logic       m_shown[2];
   logic       m_rdy  [2];
   logic       m_zero [2];
   logic [3:0] m_last [2];
   logic [3:0] m_res  [2];
   logic [3:0] m_a    [2];
   logic [3:0] m_b    [2];
   logic [1:0] m_sel  [2];
   logic [7:0] m_cnt  [2];
   int         m_cyc  [2];
   int         m_due  [2];

   task automatic reset_model(input int k);
      m_busy[k] = 1'b0; m_shown[k] = 1'b0; m_rdy[k] = 1'b0; m_zero[k] = 1'b0;
      m_last[k] = 4'd0; m_res[k] = 4'd0; m_a[k] = 4'd0; m_b[k] = 4'd0;
      m_sel[k] = 2'd0; m_cnt[k] = 8'd0; m_cyc[k] = 0; m_due[k] = 0;
   endtask

   task automatic step_model(input int k, input int settle, input logic v, input logic [1:0] op,
                             input logic [3:0] a, input logic [3:0] b, input logic ch, input logic rr);
      logic [3:0] opa;
      m_cyc[k] = m_cyc[k] + 1;
      opa = ch ? m_last[k] : a;
      if (!m_busy[k] && m_rdy[k] && v) begin
         m_busy[k] = 1'b1;
         m_sel[k] = op; m_a[k] = opa; m_b[k] = b;
         m_res[k] = alu_ref(op, opa, b);
         m_due[k] = m_cyc[k] + settle;
      end else if (m_busy[k] && m_shown[k] && rr) begin
         m_busy[k] = 1'b0;
         m_shown[k] = 1'b0;
         m_cnt[k] = m_cnt[k] + 8'd1;
      end else if (m_busy[k] && !m_shown[k] && (m_cyc[k] == m_due[k])) begin
         m_shown[k] = 1'b1;
         m_last[k] = m_res[k];
         m_zero[k] = (m_res[k] == 4'd0);
      end
      m_rdy[k] = !m_busy[k];
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            reset_model(0);
            reset_model(1);
         end else begin
            step_model(0, 1, v1, op1, a1, b1, ch1, rr1);
            step_model(1, 3, v3, op3, a3, b3, ch3, rr3);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_dut(input int k, input string p, input logic rdy, input logic rv,
                              input logic [3:0] rd, input logic z, input logic [1:0] sel,
                              input logic [3:0] oa, input logic [3:0] ob, input logic [7:0] cnt);
      checkOutput({p, ".cmd_ready"}, 8'(rdy), 8'(m_rdy[k]));
      checkOutput({p, ".res_valid"}, 8'(rv),  8'(m_shown[k]));
      checkOutput({p, ".res_data"},  8'(rd),  8'(m_last[k]));
      checkOutput({p, ".res_zero"},  8'(z),   8'(m_zero[k]));
      checkOutput({p, ".selector"},  8'(sel), 8'(m_sel[k]));
      checkOutput({p, ".opnd_a"},    8'(oa),  8'(m_a[k]));
      checkOutput({p, ".opnd_b"},    8'(ob),  8'(m_b[k]));
      checkOutput({p, ".op_cnt"},    cnt,     m_cnt[k]);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            compare_dut(0, "d1", rdy1, rv1, rd1, z1, sel1, oa1, ob1, cnt1);
            compare_dut(1, "d3", rdy3, rv3, rd3, z3, sel3, oa3, ob3, cnt3);
         end
      end
   end

   function automatic logic rdy_of(input int k);
      return (k == 0) ? rdy1 : rdy3;
   endfunction

   function automatic logic rv_of(input int k);
      return (k == 0) ? rv1 : rv3;
   endfunction

   task automatic drive(input int k, input logic v, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic ch);
      if (k == 0) begin
         v1 = v; op1 = op; a1 = a; b1 = b; ch1 = ch;
      end else begin
         v3 = v; op3 = op; a3 = a; b3 = b; ch3 = ch;
      end
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(input int k, input logic [1:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic ch);
      int n = 0;
      string p = (k == 0) ? "d1" : "d3";
      drive(k, 1'b1, op, a, b, ch);
      while (rdy_of(k) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput({p, ".accept_wait"}, 8'(rdy_of(k)), 8'd1);
      @(negedge clk);
      drive(k, 1'b0, op, a, b, ch);
   endtask

   task automatic wait_result(input int k);
      int n = 0;
      string p = (k == 0) ? "d1" : "d3";
      while (rv_of(k) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput({p, ".result_wait"}, 8'(rv_of(k)), 8'd1);
   endtask

   task automatic do_handoff(input int k);
      if (k == 0) rr1 = 1'b1; else rr3 = 1'b1;
      @(negedge clk);
      if (k == 0) rr1 = 1'b0; else rr3 = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      started = 1'b1;
      checkOutput("reset.cmd_ready", 8'(rdy1), 8'd0);
      checkOutput("reset.op_cnt", cnt1, 8'd0);
      checkOutput("reset.res_zero", 8'(z1), 8'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("release.ready_low", 8'(rdy1), 8'd0);
      @(negedge clk);
      checkOutput("release.ready_high", 8'(rdy1), 8'd1);

      // add 0111 + 0011
      applyStimulus(0, 2'b00, 4'b0111, 4'b0011, 1'b0);
      checkOutput("add.valid_early", 8'(rv1), 8'd0);
      @(negedge clk);
      checkOutput("add.valid", 8'(rv1), 8'd1);
      checkOutput("add.data", 8'(rd1), 8'h0a);
      checkOutput("add.zero", 8'(z1), 8'd0);
      do_handoff(0);
      checkOutput("add.op_cnt", cnt1, 8'd1);

      // subtract to zero, then chained XOR
      applyStimulus(0, 2'b01, 4'b0101, 4'b0101, 1'b0);
      wait_result(0);
      checkOutput("sub.data", 8'(rd1), 8'h00);
      checkOutput("sub.zero", 8'(z1), 8'd1);
      do_handoff(0);
      applyStimulus(0, 2'b11, 4'b1010, 4'b1111, 1'b1);
      checkOutput("chain.opnd_a", 8'(oa1), 8'h00);
      wait_result(0);
      checkOutput("chain.data", 8'(rd1), 8'h0f);
      do_handoff(0);

      // back-pressure with a waiting command
      applyStimulus(0, 2'b00, 4'b0010, 4'b0100, 1'b0);
      wait_result(0);
      drive(0, 1'b1, 2'b10, 4'b1111, 4'b1001, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bp.valid", 8'(rv1), 8'd1);
         checkOutput("bp.data", 8'(rd1), 8'h06);
         checkOutput("bp.ready", 8'(rdy1), 8'd0);
      end
      do_handoff(0);
      checkOutput("bp.ready_after", 8'(rdy1), 8'd1);
      checkOutput("bp.no_accept", 8'(ob1), 8'h04);
      checkOutput("bp.op_cnt", cnt1, 8'd4);
      @(negedge clk);
      drive(0, 1'b0, 2'b10, 4'b1111, 4'b1001, 1'b0);
      checkOutput("bp.accepted", 8'(ob1), 8'h09);
      wait_result(0);
      checkOutput("bp.data2", 8'(rd1), 8'h09);
      do_handoff(0);
      checkOutput("bp.op_cnt2", cnt1, 8'd5);

      // 256 more handshakes wrap the counter back
      for (int i = 0; i < 256; i++) begin
         applyStimulus(0, 2'(i), 4'(i), 4'(i >> 4), 1'b0);
         wait_result(0);
         do_handoff(0);
      end
      checkOutput("wrap.op_cnt", cnt1, 8'd5);

      // leave d1 parked in DONE while d3 runs
      applyStimulus(0, 2'b00, 4'b0001, 4'b0001, 1'b0);
      wait_result(0);

      // SETTLE=3 AND
      applyStimulus(1, 2'b10, 4'b1100, 4'b1010, 1'b0);
      checkOutput("and.selector", 8'(sel3), 8'h02);
      checkOutput("and.opnd_a", 8'(oa3), 8'h0c);
      checkOutput("and.opnd_b", 8'(ob3), 8'h0a);
      checkOutput("and.valid0", 8'(rv3), 8'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("and.valid_hold", 8'(rv3), 8'd0);
         checkOutput("and.sel_hold", 8'(sel3), 8'h02);
         checkOutput("and.a_hold", 8'(oa3), 8'h0c);
      end
      @(negedge clk);
      checkOutput("and.valid", 8'(rv3), 8'd1);
      checkOutput("and.data", 8'(rd3), 8'h08);
      do_handoff(1);
      checkOutput("and.op_cnt", cnt3, 8'd1);

      // reset in the middle of a SETTLE=3 operation
      applyStimulus(1, 2'b00, 4'b0011, 4'b0100, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort.ready", 8'(rdy3), 8'd0);
      checkOutput("abort.valid", 8'(rv3), 8'd0);
      checkOutput("abort.data", 8'(rd3), 8'h00);
      checkOutput("abort.sel", 8'(sel3), 8'h00);
      checkOutput("abort.opnd_a", 8'(oa3), 8'h00);
      checkOutput("abort.opnd_b", 8'(ob3), 8'h00);
      checkOutput("abort.op_cnt", cnt3, 8'd0);
      checkOutput("abort.d1_valid", 8'(rv1), 8'd0);
      checkOutput("abort.d1_op_cnt", cnt1, 8'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("abort.ready_low", 8'(rdy3), 8'd0);
      @(negedge clk);
      checkOutput("abort.ready_high", 8'(rdy3), 8'd1);

      // chained command as the first after reset uses zero
      applyStimulus(1, 2'b11, 4'b1111, 4'b0110, 1'b1);
      checkOutput("chain0.opnd_a", 8'(oa3), 8'h00);
      wait_result(1);
      checkOutput("chain0.data", 8'(rd3), 8'h06);
      do_handoff(1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
